rggen_host_if_apb: RTL and testbench
====================================

Name: rggen_host_if_apb

Overview:
- APB3/APB4 slave front end for the generated register block.
- Converts one APB transfer into the internal register command bus: command_valid, write, address, write_data and per-bit write_mask. Every register and bit-field instance (w0s/w1s, rw, rc, …) consumes this bus.
- Collects per-register hit/ready/read-data responses and returns PREADY, PRDATA and PSLVERR.
- Sits directly upstream of the register/bit-field layer.

Parameters:
- ADDRESS_WIDTH, 16, width of PADDR and o_address (byte address).
- DATA_WIDTH, 32, bus data width; must be a multiple of 8.
- TOTAL_REGISTERS, 1, number of register response slots.
- TIMEOUT_CYCLES, 16, access cycles without ready before an error response; 0 disables the timeout.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- i_psel, in, 1, APB select.
- i_penable, in, 1, APB enable.
- i_pwrite, in, 1, APB write.
- i_paddr, in, ADDRESS_WIDTH, APB address.
- i_pwdata, in, DATA_WIDTH, APB write data.
- i_pstrb, in, DATA_WIDTH/8, APB byte strobes.
- o_pready, out, 1, APB ready.
- o_prdata, out, DATA_WIDTH, APB read data.
- o_pslverr, out, 1, APB error.
- o_command_valid, out, 1, register command strobe.
- o_write, out, 1, 1 = write command.
- o_address, out, ADDRESS_WIDTH, registered PADDR.
- o_write_data, out, DATA_WIDTH, registered PWDATA.
- o_write_mask, out, DATA_WIDTH, per-bit mask expanded from strobes.
- i_register_active, in, TOTAL_REGISTERS, register n decodes o_address.
- i_register_ready, in, TOTAL_REGISTERS, register n completes this cycle.
- i_register_read_data, in, TOTAL_REGISTERS*DATA_WIDTH, packed read data; slot n at bits [n*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0: o_pready, o_pslverr, o_prdata, o_command_valid, o_write, o_address, o_write_data, o_write_mask. Timeout counter 0. Reset mid-transfer aborts the transfer silently; no pready is issued.
- State IDLE:
  - On i_psel=1 & i_penable=0 (setup phase), capture i_pwrite, i_paddr and i_pwdata.
  - Capture the mask: bit k = i_pstrb[k/8] & i_pwrite. Read mask is all zero.
  - Next state COMMAND.
  - Any other input combination is ignored.
- State COMMAND:
  - o_command_valid=1; captured fields drive o_write/o_address/o_write_data/o_write_mask.
  - Let hit = |i_register_active and rdy = |(i_register_active & i_register_ready).
  - hit=0: next RESPONSE with error=1, read data 0. Decode miss costs one command cycle.
  - hit=1 & rdy=1: next RESPONSE, error=0. Read data = OR over n of (active[n] & ready[n] ? slot n : 0), registered into o_prdata.
  - hit=1 & rdy=0: stay in COMMAND and increment the timeout counter.
  - Timeout: if TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 while not ready, next RESPONSE with error=1, read data 0.
- State RESPONSE:
  - o_pready=1 and o_pslverr=error for exactly one cycle; o_command_valid=0.
  - Next state IDLE; counter cleared.
  - o_prdata holds its value until the next capture and is only meaningful when o_pready=1.
- Minimum transfer: setup (T0) → command (T1) → pready (T2). Zero-wait-state registers give exactly one APB wait state.
- Reads never produce a non-zero write mask, so bit fields cannot change on a read.
- i_penable dropping or i_psel deasserting mid-transfer is an APB protocol violation. The FSM still completes the transfer and does not re-sample.
- Back-to-back transfers: a setup phase in the cycle after pready is accepted; IDLE lasts that single cycle.
- Multiple active registers (overlapping decode) are not an error. Their read data is OR-combined.

Decomposition:
- Package rggen_rtl_pkg: state enum (IDLE, COMMAND, RESPONSE) and a byte-strobe-to-bit-mask function.
- Sub-module rggen_response_mux (inputs TOTAL_REGISTERS, DATA_WIDTH):
  - reduces active/ready/read_data to hit, rdy and read_data;
  - purely combinational;
  - reused by the other host-interface variants.

Test Plan:
- Write, 1 register, always ready, PADDR=0x0004, PWDATA=0xA5A5_0001, PSTRB=4'b0011:
  - T1: command_valid=1, write=1, mask=0x0000_FFFF.
  - T2: pready=1, pslverr=0.
  - Downstream w1s bit 0 sets.
- Read, register returns 0x1234_5678 with ready in T1 → T2: pready=1, prdata=0x1234_5678, pslverr=0, mask=0 throughout.
- Read, no register active → T2: pready=1, pslverr=1, prdata=0.
- Register active but ready delayed 3 cycles (TIMEOUT_CYCLES=16) → command_valid high for 4 cycles, then pready one cycle later, pslverr=0.
- Register active, never ready, TIMEOUT_CYCLES=4 → command_valid high for 4 cycles, then pready=1, pslverr=1.
- rst_n pulsed low while in COMMAND → all outputs 0 immediately; no pready afterwards; the next setup is served normally.

Source files
------------

// File: rtl/rggen_rtl_pkg.sv
// Shared types and helpers for the rggen host interface variants.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMMAND,
        RESPONSE
    } rggen_state_e;

    // A read passes enable=0 so that no bit field can be modified by it.
    function automatic logic [7:0] strobe_to_byte_mask(
        input logic strobe,
        input logic enable
    );
        return {8{strobe & enable}};
    endfunction

endpackage

// File: rtl/rggen_response_mux.sv
// Reduces per-register hit/ready/read-data responses into a single response.
module rggen_response_mux #(
    parameter int TOTAL_REGISTERS = 1,
    parameter int DATA_WIDTH      = 32
) (
    input  logic [TOTAL_REGISTERS-1:0]            i_register_active,
    input  logic [TOTAL_REGISTERS-1:0]            i_register_ready,
    input  logic [TOTAL_REGISTERS*DATA_WIDTH-1:0] i_register_read_data,
    output logic                                  o_hit,
    output logic                                  o_ready,
    output logic [DATA_WIDTH-1:0]                 o_read_data
);

    // Overlapping decodes are legal; their read data is simply OR-combined.
    always_comb begin
        o_hit       = |i_register_active;
        o_ready     = |(i_register_active & i_register_ready);
        o_read_data = '0;
        for (int n = 0; n < TOTAL_REGISTERS; n++) begin
            if (i_register_active[n] && i_register_ready[n]) begin
                o_read_data = o_read_data | i_register_read_data[n*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/rggen_host_if_apb.sv
// APB3/APB4 slave front end driving the register command bus.
module rggen_host_if_apb
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH   = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int TOTAL_REGISTERS = 1,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_psel,
    input  logic                                  i_penable,
    input  logic                                  i_pwrite,
    input  logic [ADDRESS_WIDTH-1:0]              i_paddr,
    input  logic [DATA_WIDTH-1:0]                 i_pwdata,
    input  logic [DATA_WIDTH/8-1:0]               i_pstrb,
    output logic                                  o_pready,
    output logic [DATA_WIDTH-1:0]                 o_prdata,
    output logic                                  o_pslverr,
    output logic                                  o_command_valid,
    output logic                                  o_write,
    output logic [ADDRESS_WIDTH-1:0]              o_address,
    output logic [DATA_WIDTH-1:0]                 o_write_data,
    output logic [DATA_WIDTH-1:0]                 o_write_mask,
    input  logic [TOTAL_REGISTERS-1:0]            i_register_active,
    input  logic [TOTAL_REGISTERS-1:0]            i_register_ready,
    input  logic [TOTAL_REGISTERS*DATA_WIDTH-1:0] i_register_read_data
);

    localparam int STROBE_WIDTH  = DATA_WIDTH / 8;
    localparam int COUNTER_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_LAST =
        COUNTER_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    rggen_state_e             state;
    logic [COUNTER_WIDTH-1:0] wait_count;
    logic [DATA_WIDTH-1:0]    write_mask_next;
    logic                     hit;
    logic                     ready;
    logic [DATA_WIDTH-1:0]    read_data;
    logic                     timed_out;

    rggen_response_mux #(
        .TOTAL_REGISTERS (TOTAL_REGISTERS),
        .DATA_WIDTH      (DATA_WIDTH)
    ) u_response_mux (
        .i_register_active    (i_register_active),
        .i_register_ready     (i_register_ready),
        .i_register_read_data (i_register_read_data),
        .o_hit                (hit),
        .o_ready              (ready),
        .o_read_data          (read_data)
    );

    always_comb begin
        write_mask_next = '0;
        for (int b = 0; b < STROBE_WIDTH; b++) begin
            write_mask_next[8*b +: 8] = strobe_to_byte_mask(i_pstrb[b], i_pwrite);
        end
        timed_out = (TIMEOUT_CYCLES != 0) && (wait_count == TIMEOUT_LAST);
    end

    // Decode miss, ready and timeout all end the command phase; only a ready
    // completion is error-free, and the mux already yields zero data otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            wait_count      <= '0;
            o_pready        <= 1'b0;
            o_pslverr       <= 1'b0;
            o_prdata        <= '0;
            o_command_valid <= 1'b0;
            o_write         <= 1'b0;
            o_address       <= '0;
            o_write_data    <= '0;
            o_write_mask    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_psel && !i_penable) begin
                        state           <= COMMAND;
                        o_command_valid <= 1'b1;
                        o_write         <= i_pwrite;
                        o_address       <= i_paddr;
                        o_write_data    <= i_pwdata;
                        o_write_mask    <= write_mask_next;
                    end
                end
                COMMAND: begin
                    if (!hit || ready || timed_out) begin
                        state           <= RESPONSE;
                        o_command_valid <= 1'b0;
                        o_pready        <= 1'b1;
                        o_pslverr       <= !ready;
                        o_prdata        <= read_data;
                    end else begin
                        wait_count <= wait_count + 1'b1;
                    end
                end
                RESPONSE: begin
                    state      <= IDLE;
                    wait_count <= '0;
                    o_pready   <= 1'b0;
                    o_pslverr  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rggen_host_if_apb.sv
// Self-checking bench for rggen_host_if_apb: table vectors, random transfers, corner sequences.
module tb_rggen_host_if_apb;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  active;
        int          delay;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        exp_err;
        logic [31:0] exp_prdata;
        logic [31:0] exp_mask;
        int          exp_cycles;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           psel, penable, pwrite;
    logic [AW-1:0]  paddr;
    logic [DW-1:0]  pwdata;
    logic [DW/8-1:0] pstrb;
    logic [NR-1:0]  reg_active, reg_ready;
    logic [NR*DW-1:0] reg_read_data;

    logic           o_pready, o_pslverr, o_command_valid, o_write;
    logic [DW-1:0]  o_prdata, o_write_data, o_write_mask;
    logic [AW-1:0]  o_address;

    logic           t4_pready, t4_pslverr, t4_command_valid, t4_write;
    logic [DW-1:0]  t4_prdata, t4_write_data, t4_write_mask;
    logic [AW-1:0]  t4_address;

    int checks = 0;
    int failures = 0;
    int transfers_done = 0;

    always #5 clk = ~clk;

    rggen_host_if_apb #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TOTAL_REGISTERS(NR), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite),
        .i_paddr(paddr), .i_pwdata(pwdata), .i_pstrb(pstrb),
        .o_pready(o_pready), .o_prdata(o_prdata), .o_pslverr(o_pslverr),
        .o_command_valid(o_command_valid), .o_write(o_write), .o_address(o_address),
        .o_write_data(o_write_data), .o_write_mask(o_write_mask),
        .i_register_active(reg_active), .i_register_ready(reg_ready),
        .i_register_read_data(reg_read_data)
    );

    rggen_host_if_apb #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TOTAL_REGISTERS(NR), .TIMEOUT_CYCLES(4)
    ) dut_t4 (
        .clk(clk), .rst_n(rst_n), .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite),
        .i_paddr(paddr), .i_pwdata(pwdata), .i_pstrb(pstrb),
        .o_pready(t4_pready), .o_prdata(t4_prdata), .o_pslverr(t4_pslverr),
        .o_command_valid(t4_command_valid), .o_write(t4_write), .o_address(t4_address),
        .o_write_data(t4_write_data), .o_write_mask(t4_write_mask),
        .i_register_active(reg_active), .i_register_ready(reg_ready),
        .i_register_read_data(reg_read_data)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: expected response derived from the transfer rules alone.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_mask = '0;
        for (int b = 0; b < 4; b++)
            if (v.wr && v.strb[b]) r.exp_mask[8*b +: 8] = 8'hFF;
        if (v.active == 2'b00) begin
            r.exp_err = 1'b1; r.exp_cycles = 1; r.exp_prdata = '0;
        end else if (v.delay < TIMEOUT) begin
            r.exp_err = 1'b0; r.exp_cycles = v.delay + 1;
            r.exp_prdata = (v.active[0] ? v.rd0 : 32'h0) | (v.active[1] ? v.rd1 : 32'h0);
        end else begin
            r.exp_err = 1'b1; r.exp_cycles = TIMEOUT; r.exp_prdata = '0;
        end
        return r;
    endfunction

    task automatic applyStimulus(input vec_t v, output int t4_cycles, output logic t4_err, output int t4_pready_cycles);
        int   cmd = 0;
        int   guard = 0;
        logic done = 1'b0;
        t4_cycles = 0; t4_err = 1'b0; t4_pready_cycles = 0;
        @(negedge clk);
        if (transfers_done > 0) checkOutput("pready_single_cycle", 64'(o_pready), 64'(0));
        psel = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.addr; pwdata = v.wdata; pstrb = v.strb;
        reg_active = v.active; reg_ready = '0; reg_read_data = {v.rd1, v.rd0};
        @(negedge clk);
        penable = 1'b1;
        while (!done && guard < 64) begin
            if (t4_command_valid) t4_cycles++;
            if (t4_pready) begin t4_pready_cycles++; t4_err = t4_pslverr; end
            if (o_pready) begin
                done = 1'b1;
            end else begin
                if (o_command_valid) begin
                    if (cmd == 0) begin
                        checkOutput("cmd_write", 64'(o_write), 64'(v.wr));
                        checkOutput("cmd_address", 64'(o_address), 64'(v.addr));
                        checkOutput("cmd_write_data", 64'(o_write_data), 64'(v.wdata));
                        checkOutput("cmd_write_mask", 64'(o_write_mask), 64'(v.exp_mask));
                    end else if (!v.wr) begin
                        checkOutput("read_mask_zero", 64'(o_write_mask), 64'(0));
                    end
                    reg_ready = (cmd == v.delay) ? v.active : 2'b00;
                    cmd++;
                end
                guard++;
                @(negedge clk);
            end
        end
        if (!done) begin
            checks++; failures++;
            $display("[TB] FAIL pready_wait: got no pready within 64 cycles, expected pready");
        end else begin
            checkOutput("pslverr", 64'(o_pslverr), 64'(v.exp_err));
            checkOutput("prdata", 64'(o_prdata), 64'(v.exp_prdata));
            checkOutput("command_cycles", 64'(cmd), 64'(v.exp_cycles));
            checkOutput("valid_low_in_response", 64'(o_command_valid), 64'(0));
        end
        reg_ready = '0;
        transfers_done++;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[7];
        vec_t v;
        int t4c, t4p;
        logic t4e;
        int seen;

        vecs[0] = '{1'b1, 16'h0004, 32'hA5A5_0001, 4'b0011, 2'b01, 0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0000_FFFF, 1};
        vecs[1] = '{1'b0, 16'h0008, 32'h0, 4'b1111, 2'b01, 0, 32'h1234_5678, 32'h0, 1'b0, 32'h1234_5678, 32'h0, 1};
        vecs[2] = '{1'b0, 16'h0100, 32'h0, 4'b1111, 2'b00, 0, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 32'h0, 1};
        vecs[3] = '{1'b0, 16'h0010, 32'h0, 4'b0000, 2'b10, 3, 32'h0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 32'h0, 4};
        vecs[4] = '{1'b0, 16'h0014, 32'h0, 4'b0000, 2'b11, 1, 32'h0F0F_0000, 32'h0000_F0F0, 1'b0, 32'h0F0F_F0F0, 32'h0, 2};
        vecs[5] = '{1'b1, 16'hFFFC, 32'hFFFF_FFFF, 4'b1000, 2'b10, 0, 32'h0, 32'h0, 1'b0, 32'h0, 32'hFF00_0000, 1};
        vecs[6] = '{1'b1, 16'h0020, 32'h5555_AAAA, 4'b0000, 2'b01, 2, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 3};

        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
        reg_active = '0; reg_ready = '0; reg_read_data = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_ctrl", 64'({o_pready, o_pslverr, o_command_valid, o_write}), 64'(0));
        checkOutput("reset_address", 64'(o_address), 64'(0));
        checkOutput("reset_wdata", 64'(o_write_data), 64'(0));
        checkOutput("reset_mask", 64'(o_write_mask), 64'(0));
        checkOutput("reset_prdata", 64'(o_prdata), 64'(0));
        rst_n = 1'b1;

        // Table vectors run back to back with no idle gap between transfers.
        for (int i = 0; i < 7; i++) applyStimulus(vecs[i], t4c, t4e, t4p);

        // Never-ready register: 16-cycle instance and 4-cycle instance both time out.
        v = '{1'b0, 16'h0030, 32'h0, 4'b0000, 2'b01, 100, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0, 32'h0, 0};
        v = model(v);
        applyStimulus(v, t4c, t4e, t4p);
        checkOutput("t4_command_cycles", 64'(t4c), 64'(4));
        checkOutput("t4_pslverr", 64'(t4e), 64'(1));
        checkOutput("t4_pready_cycles", 64'(t4p), 64'(1));

        // Reset pulse while in COMMAND aborts silently.
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0040; pwdata = 32'h1357_9BDF; pstrb = 4'b1111;
        reg_active = 2'b01; reg_ready = '0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        checkOutput("pre_reset_valid", 64'(o_command_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_ctrl", 64'({o_pready, o_pslverr, o_command_valid, o_write}), 64'(0));
        checkOutput("async_reset_fields", 64'(o_address | o_write_data | o_write_mask | o_prdata), 64'(0));
        @(negedge clk);
        rst_n = 1'b1; psel = 1'b0; penable = 1'b0; reg_active = '0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (o_pready || o_command_valid) seen++;
        end
        checkOutput("no_activity_after_reset", 64'(seen), 64'(0));
        applyStimulus(vecs[1], t4c, t4e, t4p);

        // Random transfers with occasional idle gaps, checked against the model.
        for (int i = 0; i < 30; i++) begin
            v.wr = 1'($urandom); v.addr = 16'($urandom); v.wdata = $urandom; v.strb = 4'($urandom);
            v.active = 2'($urandom); v.rd0 = $urandom; v.rd1 = $urandom;
            v.delay = ($urandom_range(0, 5) == 0) ? int'($urandom_range(16, 20)) : int'($urandom_range(0, 6));
            v = model(v);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                psel = 1'b0; penable = 1'b0;
            end
            applyStimulus(v, t4c, t4e, t4p);
        end

        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
